// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
//   Computes a WIDTH-bit add or subtract through one external 4-bit adder slice.
//   The slice is used once per cycle, least-significant nibble first.
//   The carry between nibbles is held in a register.
//   Subtract is done as A + ~B + 1: B is inverted at accept and the first carry-in is 1.
//
// Ports
//   clock, reset_n            rising-edge clock, asynchronous active-low reset
//   start_valid/start_ready   operation request handshake (operands sampled on accept)
//   op_a, op_b, op_sub        operands; op_sub=1 selects A - B
//   slice_a/b/cin             nibble operands and carry-in driven to the shared slice
//   slice_sum/cout            combinational result from the slice
//   result_valid/ready        result handshake
//   result, cout, overflow    sum/difference, MSB carry-out (1 = no borrow), signed overflow
//   busy                      high while an operation is in flight or awaiting pickup

module nibble_serial_add_ctrl #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NIBBLES = WIDTH / 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_sub,
    output logic [3:0]       slice_a,
    output logic [3:0]       slice_b,
    output logic             slice_cin,
    input  logic [3:0]       slice_sum,
    input  logic             slice_cout,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned CntW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start_valid) begin
                    state_d  = StRun;
                    a_d      = op_a;
                    b_d      = op_sub ? ~op_b : op_b;
                    carry_d  = op_sub;
                    cnt_d    = '0;
                    sign_a_d = op_a[WIDTH-1];
                    sign_b_d = op_sub ? ~op_b[WIDTH-1] : op_b[WIDTH-1];
                end
            end
            StRun: begin
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                // Each slice sum enters at the top, so after NIBBLES passes the
                // first nibble has reached bits [3:0].
                sum_d   = {slice_sum, sum_q[WIDTH-1:4]};
                carry_d = slice_cout;
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    cout_d  = slice_cout;
                    // Overflow: both operand signs agree and the result sign differs.
                    ovf_d   = (sign_a_q == sign_b_q) && (slice_sum[3] != sign_a_q);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (result_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        start_ready  = (state_q == StIdle);
        result_valid = (state_q == StDone);
        busy         = (state_q != StIdle);
        slice_a      = (state_q == StRun) ? a_q[3:0] : 4'h0;
        slice_b      = (state_q == StRun) ? b_q[3:0] : 4'h0;
        slice_cin    = (state_q == StRun) ? carry_q  : 1'b0;
        result       = sum_q;
        cout         = cout_q;
        overflow     = ovf_q;
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl.
// It contains a behavioural 4-bit slice and a reference model.
// The reference model computes each operation in one full-width arithmetic step.
module tb_nibble_serial_add_ctrl;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned NIBBLES = WIDTH / 4;

    logic             clock;
    logic             reset_n;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_sub;
    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic             slice_cin;
    logic [3:0]       slice_sum;
    logic             slice_cout;
    logic             result_valid;
    logic             result_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             busy;

    nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .op_a         (op_a),
        .op_b         (op_b),
        .op_sub       (op_sub),
        .slice_a      (slice_a),
        .slice_b      (slice_b),
        .slice_cin    (slice_cin),
        .slice_sum    (slice_sum),
        .slice_cout   (slice_cout),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .cout         (cout),
        .overflow     (overflow),
        .busy         (busy)
    );

    // The shared 4-bit adder slice.
    logic [4:0] slice_tot;
    assign slice_tot  = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0, slice_cin};
    assign slice_sum  = slice_tot[3:0];
    assign slice_cout = slice_tot[4];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 idle, 1 computing, 2 result waiting.
    int               m_state;
    int               m_k;
    int               m_wait;
    logic [WIDTH-1:0] m_a, m_b, m_res, m_pend_res;
    logic             m_sub, m_prev_cout, m_cout, m_ovf, m_pend_cout, m_pend_ovf;
    int               cyc, n_acc, acc_last, acc_prev;

    always @(posedge clock or negedge reset_n) begin
        logic [WIDTH:0] full;
        if (!reset_n) begin
            m_state = 0;
            m_res   = '0;
            m_cout  = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            cyc++;
            case (m_state)
                0: if (start_valid) begin
                    m_a         = op_a;
                    m_b         = op_sub ? ~op_b : op_b;
                    m_sub       = op_sub;
                    full        = {1'b0, m_a} + {1'b0, m_b} + {{WIDTH{1'b0}}, op_sub};
                    m_pend_res  = full[WIDTH-1:0];
                    m_pend_cout = full[WIDTH];
                    m_pend_ovf  = (m_a[WIDTH-1] == m_b[WIDTH-1]) &&
                                  (full[WIDTH-1] != m_a[WIDTH-1]);
                    m_k         = 0;
                    m_state     = 1;
                    n_acc++;
                    acc_prev    = acc_last;
                    acc_last    = cyc;
                end
                1: begin
                    m_prev_cout = slice_cout;
                    if (m_k == int'(NIBBLES) - 1) begin
                        m_state = 2;
                        m_res   = m_pend_res;
                        m_cout  = m_pend_cout;
                        m_ovf   = m_pend_ovf;
                    end else begin
                        m_k++;
                    end
                end
                default: if (result_ready) m_state = 0;
            endcase
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clock) begin
        if (reset_n) begin
            chk("start_ready", start_ready, m_state == 0);
            chk("busy", busy, m_state != 0);
            chk("result_valid", result_valid, m_state == 2);
            if (m_state == 1) begin
                chk("slice_a", slice_a, m_a[4*m_k +: 4]);
                chk("slice_b", slice_b, m_b[4*m_k +: 4]);
                chk("slice_cin", slice_cin, (m_k == 0) ? m_sub : m_prev_cout);
            end else begin
                chk("slice_idle", {slice_a, slice_b, slice_cin}, 0);
                chk("result", result, m_res);
                chk("cout", cout, m_cout);
                chk("overflow", overflow, m_ovf);
            end
        end
    end

    task automatic wait_valid(input string name, output int n);
        n = 0;
        while (!result_valid && n < 30) begin
            @(posedge clock); #1;
            n++;
        end
        if (!result_valid) chk({name, "_timeout"}, 0, 1);
    endtask

    // Called in IDLE, just after an edge, with result_ready=1.
    task automatic do_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic sub, input logic [WIDTH-1:0] er, input logic ec,
                         input logic eo);
        int n;
        op_a = a; op_b = b; op_sub = sub; start_valid = 1'b1;
        @(posedge clock); #1;
        start_valid = 1'b0;
        op_a = $urandom; op_b = $urandom; op_sub = 1'($urandom);
        wait_valid(name, n);
        chk({name, "_latency"}, n, NIBBLES);
        chk({name, "_res"}, result, er);
        chk({name, "_cout"}, cout, ec);
        chk({name, "_ovf"}, overflow, eo);
        @(posedge clock); #1;
    endtask

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        int base;
        reset_n = 1'b0; start_valid = 1'b0; op_a = '0; op_b = '0; op_sub = 1'b0;
        result_ready = 1'b1;
        cyc = 0; n_acc = 0; acc_last = 0; acc_prev = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_start_ready", start_ready, 1);
        chk("rst_outputs", {result_valid, busy, cout, overflow, slice_a, slice_b, slice_cin}, 0);
        chk("rst_result", result, 0);
        @(negedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        do_op("add_wrap", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        do_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        do_op("sub_5_7", 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        do_op("sub_7_5", 32'd7, 32'd5, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
        do_op("sub_ovf", 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Backpressure in DONE with new requests and changing operands.
        result_ready = 1'b0;
        op_a = 32'd3; op_b = 32'd4; op_sub = 1'b0; start_valid = 1'b1;
        @(posedge clock); #1;
        start_valid = 1'b0;
        wait_valid("bp", n);
        for (int i = 0; i < 5; i++) begin
            start_valid = 1'b1; op_a = $urandom; op_b = $urandom; op_sub = 1'($urandom);
            @(posedge clock); #1;
            chk("bp_hold_res", {result, cout, overflow}, {32'd7, 1'b0, 1'b0});
            chk("bp_no_accept", {start_ready, result_valid}, 2'b01);
        end
        op_a = 32'h100; op_b = 32'h23; op_sub = 1'b0; result_ready = 1'b1;
        @(posedge clock); #1;
        chk("bp_pop", {start_ready, result_valid}, 2'b10);
        @(posedge clock); #1;
        chk("bp_next_accept", busy, 1);
        start_valid = 1'b0;
        wait_valid("bp2", n);
        chk("bp2_res", result, 32'h123);
        @(posedge clock); #1;

        // Asynchronous reset mid-RUN; the carry is live at cnt=3.
        op_a = 32'hFFFF_FFFF; op_b = 32'd1; op_sub = 1'b0; start_valid = 1'b1;
        @(posedge clock); #1;
        start_valid = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        chk("pre_rst_cin", slice_cin, 1);
        reset_n = 1'b0;
        #1;
        chk("arst_ready", start_ready, 1);
        chk("arst_outs", {result_valid, busy, slice_a, slice_b, slice_cin, cout, overflow}, 0);
        chk("arst_result", result, 0);
        @(negedge clock); #1;
        reset_n = 1'b1;
        repeat (12) @(posedge clock);
        #1;
        do_op("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

        // Back-to-back requests with start_valid held.
        base = n_acc;
        op_a = 32'h0F0F_0F0F; op_b = 32'h0101_0101; op_sub = 1'b0; start_valid = 1'b1;
        n = 0;
        while (n_acc < base + 2 && n < 40) begin
            @(posedge clock); #1;
            n++;
            if (n_acc == base + 1) begin
                op_a = 32'h10; op_b = 32'h20; op_sub = 1'b1;
            end
        end
        start_valid = 1'b0;
        chk("b2b_accepts", n_acc - base, 2);
        chk("b2b_interval", acc_last - acc_prev, NIBBLES + 2);
        wait_valid("b2b", n);
        chk("b2b_res2", result, 32'hFFFF_FFF0);
        @(posedge clock); #1;

        // Random traffic, checked cycle by cycle by the model.
        for (int i = 0; i < 600; i++) begin
            start_valid  = ($urandom_range(0, 2) != 0);
            op_a         = pick();
            op_b         = pick();
            op_sub       = 1'($urandom);
            result_ready = ($urandom_range(0, 3) != 0);
            @(posedge clock); #1;
        end
        start_valid = 1'b0; result_ready = 1'b1;
        repeat (NIBBLES + 4) @(posedge clock);
        #1;
        chk("final_idle", start_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Multi-cycle sequencer that computes WIDTH-bit add/subtract by time-multiplexing one external 4-bit ripple adder slice, least-significant nibble first.
- Latches operands on a valid/ready start handshake and drives the slice one nibble per cycle, carrying between nibbles in a register.
- Returns sum, carry-out and signed overflow on a valid/ready result handshake.
- Sits between the ALU issue logic and a shared 4-bit adder slice in area-constrained builds.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIBBLES, WIDTH/4, derived number of slice passes; not overridden independently.

Ports:
- clock  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start_valid  input  1  operation request.
- start_ready  output  1  controller can accept a request.
- op_a  input  WIDTH  operand A.
- op_b  input  WIDTH  operand B.
- op_sub  input  1  1 = A - B, 0 = A + B.
- slice_a  output  4  nibble of A to the slice.
- slice_b  output  4  nibble of effective B to the slice.
- slice_cin  output  1  carry-in to the slice.
- slice_sum  input  4  slice sum, combinational from slice_a/b/cin.
- slice_cout  input  1  slice carry-out.
- result_valid  output  1  result available.
- result_ready  input  1  consumer accepts the result.
- result  output  WIDTH  sum/difference.
- cout  output  1  carry-out of the MSB nibble. For subtract, 1 means no borrow.
- overflow  output  1  two's-complement signed overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - All internal registers are cleared.
  - Outputs: start_ready=1, result_valid=0, result=0, cout=0, overflow=0, busy=0, slice_a=0, slice_b=0, slice_cin=0.
  - Reset is asserted asynchronously and released synchronously to clock.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - start_ready=1.
  - On a rising edge with start_valid=1, the controller accepts the operation and moves to RUN:
    - a_reg <= op_a; b_reg <= op_sub ? ~op_b : op_b.
    - carry <= op_sub; cnt <= 0.
    - sign_a <= op_a[WIDTH-1]; sign_b <= effective B MSB.
- RUN:
  - start_ready=0.
  - slice_a = a_reg[3:0], slice_b = b_reg[3:0], slice_cin = carry.
  - Each edge:
    - a_reg and b_reg shift right by 4.
    - The sum register shifts right by 4, with slice_sum entering bits [WIDTH-1:WIDTH-4].
    - carry <= slice_cout; cnt <= cnt+1.
  - At the edge with cnt==NIBBLES-1:
    - Go to DONE.
    - cout <= slice_cout.
    - overflow <= (sign_a==sign_b) && (slice_sum[3]!=sign_a).
  - slice outputs are 0 outside RUN.
- DONE:
  - result_valid=1.
  - result, cout and overflow are held stable.
  - On an edge with result_ready=1, go to IDLE and drop result_valid. result, cout and overflow keep their values until the next acceptance.
  - start_valid is ignored in RUN and DONE. No request is lost, because start_ready=0.
- Latency:
  - Accept edge T, result_valid high after edge T+NIBBLES (8 cycles for WIDTH=32).
  - Minimum initiation interval is NIBBLES+2 cycles.
- Operands are sampled only at the accept edge; later changes to op_a/op_b/op_sub have no effect.
- cnt wraps only through reset or a new accept; it never counts past NIBBLES-1.
- result_ready while not in DONE has no effect.
- Reset mid-RUN or in DONE discards the operation; no result_valid pulse is produced.

Test Plan:
- 0x0000_0001 + 0xFFFF_FFFF, sub=0 -> result 0x0000_0000, cout=1, overflow=0; result_valid rises 8 cycles after the accept edge.
- 0x7FFF_FFFF + 0x0000_0001, sub=0 -> result 0x8000_0000, cout=0, overflow=1. Check that slice_cin equals the previous slice_cout on every RUN cycle.
- Subtract 5 - 7 -> 0xFFFF_FFFE, cout=0, overflow=0. Subtract 7 - 5 -> 0x0000_0002, cout=1. Subtract 0x8000_0000 - 1 -> 0x7FFF_FFFF, overflow=1.
- Backpressure: hold result_ready=0 for 5 cycles in DONE with start_valid=1 and operands changing -> result/cout/overflow stable, start_ready=0, no new accept. On the result_ready edge -> IDLE, next accept on the following edge.
- Reset pulse (reset_n=0, asynchronous mid-cycle) during RUN at cnt=3 -> outputs go to reset values immediately, no result_valid. After release, 0x1234_5678 + 0x1111_1111 -> 0x2345_6789.
- Back-to-back: start_valid held high with result_ready=1 and two different operations -> both results correct, second accept exactly NIBBLES+2 cycles after the first.
